framebuffer_uart_dump: RTL and testbench

// Reads the displayed framebuffer back over a synchronous read port and streams it out of tx_out (UART 8N1) on request.

---
 rtl/fpga360_pkg.sv | 28 ++
 rtl/uart_tx_byte.sv | 56 +++++
 rtl/framebuffer_uart_dump.sv | 129 ++++++++++++
 tb/tb_framebuffer_uart_dump.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga360_pkg.sv
// Shared framebuffer types and dump-stream constants.
package fpga360_pkg;

  localparam logic [7:0] DUMP_HDR0 = 8'hA5;
  localparam logic [7:0] DUMP_HDR1 = 8'h5A;

  typedef logic [11:0] rgb12_t;
  typedef logic [8:0]  fb_x_t;
  typedef logic [7:0]  fb_y_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_FETCH,
    ST_WAIT_RD,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_CSUM,
    ST_DRAIN,
    ST_DONE
  } dump_state_t;

  function automatic logic [7:0] rgb_hi_byte(input rgb12_t p);
    return {4'h0, p[11:8]};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter with valid/ready input; ready also in the last stop-bit cycle
// so consecutive bytes go out with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic [7:0] data_in,
  output logic       tx_out
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic [8:0]    shreg;
  logic          last_cycle;

  assign last_cycle = active && (bit_cnt == 4'd9) && (baud_cnt == '0);
  assign ready_out  = !active || last_cycle;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active   <= 1'b0;
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
      shreg    <= 9'h1FF;
      tx_out   <= 1'b1;
    end else if (valid_in && ready_out) begin
      active   <= 1'b1;
      bit_cnt  <= 4'd0;
      baud_cnt <= BW'(CLKS_PER_BIT - 1);
      shreg    <= {1'b1, data_in};
      tx_out   <= 1'b0;
    end else if (active) begin
      if (baud_cnt == '0) begin
        baud_cnt <= BW'(CLKS_PER_BIT - 1);
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx_out <= 1'b1;
        end else begin
          // shreg carries the stop bit behind the data, so bit 9 drives 1
          tx_out  <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/framebuffer_uart_dump.sv
// Streams the framebuffer out over UART: header, two bytes per pixel in raster order, XOR checksum.
//   state    | meaning
//   IDLE     | waiting for start_in
//   HDR0/1   | sending 0xA5 / 0x5A
//   FETCH    | rd_en_out pulse for current x/y
//   WAIT_RD  | read-latency countdown, capture rgb_in at terminal count
//   SEND_HI  | sending {4'h0, r}
//   SEND_LO  | sending {g, b}, then raster advance
//   CSUM     | sending checksum
//   DRAIN    | waiting for the checksum stop bit to finish
//   DONE     | done_out pulse, busy dropped
module framebuffer_uart_dump
  import fpga360_pkg::*;
#(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 180,
  parameter int CLKS_PER_BIT = 868,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        freeze_out,
  output logic        rd_en_out,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  input  logic [11:0] rgb_in,
  output logic        tx_out
);

  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  dump_state_t   state, state_nxt;
  logic [LW-1:0] lat_cnt;
  rgb12_t        pix_q;
  logic [7:0]    csum;
  logic          tx_valid, tx_ready, tx_xfer;
  logic [7:0]    tx_data;
  logic          last_x, last_y;

  assign last_x  = (x_out == fb_x_t'(WIDTH - 1));
  assign last_y  = (y_out == fb_y_t'(HEIGHT - 1));
  assign tx_xfer = tx_valid && tx_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start_in) state_nxt = ST_HDR0;
      ST_HDR0:    if (tx_xfer) state_nxt = ST_HDR1;
      ST_HDR1:    if (tx_xfer) state_nxt = ST_FETCH;
      ST_FETCH:   state_nxt = ST_WAIT_RD;
      ST_WAIT_RD: if (lat_cnt == '0) state_nxt = ST_SEND_HI;
      ST_SEND_HI: if (tx_xfer) state_nxt = ST_SEND_LO;
      ST_SEND_LO: if (tx_xfer) state_nxt = (last_x && last_y) ? ST_CSUM : ST_FETCH;
      ST_CSUM:    if (tx_xfer) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (tx_ready) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out   = (state != ST_IDLE) && (state != ST_DONE);
    freeze_out = busy_out;
    done_out   = (state == ST_DONE);
    rd_en_out  = (state == ST_FETCH);
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      ST_HDR0:    begin tx_valid = 1'b1; tx_data = DUMP_HDR0;          end
      ST_HDR1:    begin tx_valid = 1'b1; tx_data = DUMP_HDR1;          end
      ST_SEND_HI: begin tx_valid = 1'b1; tx_data = rgb_hi_byte(pix_q); end
      ST_SEND_LO: begin tx_valid = 1'b1; tx_data = pix_q[7:0];         end
      ST_CSUM:    begin tx_valid = 1'b1; tx_data = csum;               end
      default:    ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_out   <= 9'd0;
      y_out   <= 8'd0;
      lat_cnt <= '0;
      pix_q   <= '0;
      csum    <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: if (start_in) begin
          x_out <= 9'd0;
          y_out <= 8'd0;
          csum  <= 8'h00;
        end
        ST_FETCH: lat_cnt <= LW'(READ_LATENCY - 1);
        ST_WAIT_RD: begin
          if (lat_cnt == '0) pix_q <= rgb_in;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        ST_SEND_HI: if (tx_xfer) csum <= csum ^ tx_data;
        ST_SEND_LO: if (tx_xfer) begin
          csum <= csum ^ tx_data;
          if (last_x) begin
            x_out <= 9'd0;
            y_out <= last_y ? 8'd0 : y_out + 8'd1;
          end else begin
            x_out <= x_out + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (tx_valid),
    .ready_out (tx_ready),
    .data_in   (tx_data),
    .tx_out    (tx_out)
  );

endmodule

// File: tb/tb_framebuffer_uart_dump.sv
// Bench: framebuffer model with 2-cycle read latency, UART decoder and stream reference model.
module tb_framebuffer_uart_dump;

  localparam int W = 4;
  localparam int H = 2;
  localparam int CPB = 4;
  localparam int NBYTES = 2 + 2 * W * H + 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        busy_out, done_out, freeze_out, rd_en_out, tx_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [11:0] rgb_in = 12'h000;

  framebuffer_uart_dump #(
    .WIDTH(W), .HEIGHT(H), .CLKS_PER_BIT(CPB), .READ_LATENCY(2)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start_in   (start_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .freeze_out (freeze_out),
    .rd_en_out  (rd_en_out),
    .x_out      (x_out),
    .y_out      (y_out),
    .rgb_in     (rgb_in),
    .tx_out     (tx_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // framebuffer model: data appears two cycles after the strobe, noise otherwise
  logic [11:0] fb [W*H];
  logic        noise_en = 1'b0;
  logic        v1 = 1'b0;
  int          a1 = 0;
  always @(posedge clk_in) begin
    v1 <= rd_en_out;
    a1 <= int'(y_out) * W + int'(x_out);
    if (v1) rgb_in <= fb[a1];
    else    rgb_in <= noise_en ? 12'($urandom) : 12'h000;
  end

  int rd_cnt = 0;
  always @(negedge clk_in) if (rd_en_out) rd_cnt++;

  // UART decoder, sampling one cycle into each bit
  logic [7:0] rx_q [$];
  logic [9:0] rx_sh;
  logic       rx_act = 1'b0;
  logic       prev_tx = 1'b1;
  int rx_t = 0, first_start = -1, last_start = 0;
  int timing_bad = 0, gap_bad = 0, frame_bad = 0;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      rx_act = 1'b0;
    end else begin
      if (tx_out !== prev_tx && first_start >= 0 && ((cyc - first_start) % CPB) != 0)
        timing_bad++;
      if (!rx_act) begin
        if (tx_out == 1'b0) begin
          rx_act = 1'b1;
          rx_t = 0;
          if (first_start < 0) first_start = cyc;
          else if (cyc != last_start + 10 * CPB) gap_bad++;
          last_start = cyc;
        end
      end else begin
        rx_t++;
      end
      if (rx_act && (rx_t % CPB) == 1) rx_sh[rx_t / CPB] = tx_out;
      if (rx_act && rx_t == 9 * CPB + 1) begin
        if (rx_sh[0] !== 1'b0 || rx_sh[9] !== 1'b1) frame_bad++;
        rx_q.push_back(rx_sh[8:1]);
        rx_act = 1'b0;
      end
    end
    prev_tx = tx_out;
  end

  task automatic fill_xy();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        fb[y * W + x] = {4'h0, 4'(x), 4'(y)};
  endtask

  task automatic run_frame(input string tag, input bit mid_start, input bit done_start);
    logic [7:0] exp_q [$];
    logic [7:0] cs, obs;
    int s, dcnt, dcyc;
    exp_q = {8'hA5, 8'h5A};
    cs = 8'h00;
    for (int p = 0; p < W * H; p++) begin
      exp_q.push_back({4'h0, fb[p][11:8]});
      exp_q.push_back(fb[p][7:0]);
      cs = cs ^ {4'h0, fb[p][11:8]} ^ fb[p][7:0];
    end
    exp_q.push_back(cs);

    rx_q.delete();
    first_start = -1; timing_bad = 0; gap_bad = 0; frame_bad = 0; rd_cnt = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    s = cyc;
    @(negedge clk_in);
    start_in = 1'b0;
    chk({tag, "_busy_rise"}, {30'd0, busy_out, freeze_out}, 32'h3);
    dcnt = 0;
    dcyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_in);
      start_in = (mid_start && i == 300);
      if (dcnt > 0 && cyc == dcyc + 1) chk({tag, "_busy_after_done"}, busy_out, 0);
      if (done_out) begin
        dcnt++;
        if (dcyc < 0) dcyc = cyc;
        if (done_start) start_in = 1'b1;
      end
      if (dcnt > 0 && cyc > dcyc + 60) break;
    end
    start_in = 1'b0;

    chk({tag, "_done_count"}, dcnt, 1);
    chk({tag, "_latency"}, first_start - s, 2);
    chk({tag, "_frame_len"}, (dcyc - s >= 19 * 40 && dcyc - s <= 19 * 40 + 8), 1);
    chk({tag, "_nbytes"}, rx_q.size(), NBYTES);
    for (int k = 0; k < NBYTES; k++) begin
      obs = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, k), obs, exp_q[k]);
    end
    chk({tag, "_bit_grid"}, timing_bad, 0);
    chk({tag, "_no_gap"}, gap_bad, 0);
    chk({tag, "_framing"}, frame_bad, 0);
    chk({tag, "_rd_count"}, rd_cnt, W * H);
    chk({tag, "_tx_idle"}, tx_out, 1);
  endtask

  initial begin
    rst_in = 1'b0;
    start_in = 1'b0;
    fill_xy();
    repeat (3) @(negedge clk_in);
    chk("rst_tx", tx_out, 1);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_freeze", freeze_out, 0);
    chk("rst_rd_en", rd_en_out, 0);
    chk("rst_xy", {15'd0, x_out, y_out}, 0);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);

    run_frame("xy", 1'b0, 1'b0);

    for (int p = 0; p < W * H; p++) fb[p] = 12'hFFF;
    run_frame("fff", 1'b0, 1'b0);
    chk("fff_csum_zero", (rx_q.size() == NBYTES) ? rx_q[NBYTES-1] : 8'hxx, 8'h00);

    fill_xy();
    run_frame("ignore_start", 1'b1, 1'b1);

    // reset while the fifth byte is mid-bit
    rx_q.delete();
    first_start = -1;
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 1000 && rx_q.size() < 4; i++) @(negedge clk_in);
    chk("abort_reach4", rx_q.size(), 4);
    repeat (14) @(negedge clk_in);
    chk("abort_busy_before", busy_out, 1);
    rst_in = 1'b0;
    #1;
    chk("abort_tx", tx_out, 1);
    chk("abort_busy", busy_out, 0);
    chk("abort_freeze", freeze_out, 0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    run_frame("after_abort", 1'b0, 1'b0);

    noise_en = 1'b1;
    run_frame("noise", 1'b0, 1'b0);
    noise_en = 1'b0;

    for (int p = 0; p < W * H; p++) fb[p] = 12'($urandom);
    run_frame("rand", 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
